// File: rtl/calc_prio_arb.sv
// calc_prio_arb: per-port command slots split by opcode class onto two ALUs; 2-cycle request-to-valid
// latency, vld/cmd/id held while rdy is low; define PRIO_RR_EN for round-robin instead of fixed priority.
module calc_prio_arb #(
   parameter int NUM_PORTS = 4,
   parameter int CMD_W     = 4,
   parameter int SPLIT     = 4,
   parameter int ID_W      = $clog2(NUM_PORTS)
) (
   input  logic                       c_clk,
   input  logic                       reset_n,
   input  logic [NUM_PORTS*CMD_W-1:0] req_cmd,
   output logic [NUM_PORTS-1:0]       port_busy,
   output logic [NUM_PORTS-1:0]       drop_err,
   output logic                       alu1_vld,
   output logic [CMD_W-1:0]           alu1_cmd,
   output logic [ID_W-1:0]            alu1_id,
   input  logic                       alu1_rdy,
   output logic                       alu2_vld,
   output logic [CMD_W-1:0]           alu2_cmd,
   output logic [ID_W-1:0]            alu2_id,
   input  logic                       alu2_rdy
);

   typedef enum logic [1:0] {S_EMPTY, S_PENDING, S_ISSUED} slot_t;

   localparam logic [CMD_W-1:0] SPLIT_C = CMD_W'(SPLIT);

   slot_t                state_q [NUM_PORTS];
   slot_t                state_d [NUM_PORTS];
   logic [CMD_W-1:0]     cmd_q   [NUM_PORTS];
   logic [CMD_W-1:0]     cmd_d   [NUM_PORTS];
   logic [NUM_PORTS-1:0] elig1, elig2, rel, drop_d;
   logic                 hs1, hs2, free1, free2;
   logic [ID_W:0]        g1, g2;
   logic                 vld1_d, vld2_d;
   logic [CMD_W-1:0]     cmd1_d, cmd2_d;
   logic [ID_W-1:0]      id1_d, id2_d;

`ifdef PRIO_RR_EN
   logic [ID_W-1:0] ptr1_q, ptr2_q;

   // {found, id}: first eligible port after ptr, wrapping at NUM_PORTS
   function automatic logic [ID_W:0] pick(input logic [NUM_PORTS-1:0] elig, input logic [ID_W-1:0] ptr);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         idx = (int'(ptr) + i) % NUM_PORTS;
         if (elig[ID_W'(idx)]) res = {1'b1, ID_W'(idx)};
      end
      return res;
   endfunction
`else
   function automatic logic [ID_W:0] pick(input logic [NUM_PORTS-1:0] elig);
      logic [ID_W:0] res;
      res = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (elig[ID_W'(i)]) res = {1'b1, ID_W'(i)};
      end
      return res;
   endfunction
`endif

   assign hs1   = alu1_vld & alu1_rdy;
   assign hs2   = alu2_vld & alu2_rdy;
   assign free1 = ~alu1_vld | alu1_rdy;
   assign free2 = ~alu2_vld | alu2_rdy;

   // PENDING slots always hold a nonzero command, so cmd < SPLIT alone selects the add class
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         rel[p]       = (state_q[p] == S_ISSUED) &&
                        ((hs1 && alu1_id == ID_W'(p)) || (hs2 && alu2_id == ID_W'(p)));
         port_busy[p] = (state_q[p] != S_EMPTY) && !rel[p];
         elig1[p]     = (state_q[p] == S_PENDING) && (cmd_q[p] <  SPLIT_C);
         elig2[p]     = (state_q[p] == S_PENDING) && (cmd_q[p] >= SPLIT_C);
      end
   end

   always_comb begin
`ifdef PRIO_RR_EN
      g1 = pick(elig1, ptr1_q);
      g2 = pick(elig2, ptr2_q);
`else
      g1 = pick(elig1);
      g2 = pick(elig2);
`endif
      vld1_d = alu1_vld;
      cmd1_d = alu1_cmd;
      id1_d  = alu1_id;
      vld2_d = alu2_vld;
      cmd2_d = alu2_cmd;
      id2_d  = alu2_id;
      if (free1) begin
         vld1_d = g1[ID_W];
         if (g1[ID_W]) begin
            cmd1_d = cmd_q[g1[ID_W-1:0]];
            id1_d  = g1[ID_W-1:0];
         end
      end
      if (free2) begin
         vld2_d = g2[ID_W];
         if (g2[ID_W]) begin
            cmd2_d = cmd_q[g2[ID_W-1:0]];
            id2_d  = g2[ID_W-1:0];
         end
      end
      // a granted slot is PENDING and therefore busy, so grant and load never collide
      for (int p = 0; p < NUM_PORTS; p++) begin
         state_d[p] = state_q[p];
         cmd_d[p]   = cmd_q[p];
         drop_d[p]  = 1'b0;
         if (rel[p]) state_d[p] = S_EMPTY;
         if (free1 && g1[ID_W] && g1[ID_W-1:0] == ID_W'(p)) state_d[p] = S_ISSUED;
         if (free2 && g2[ID_W] && g2[ID_W-1:0] == ID_W'(p)) state_d[p] = S_ISSUED;
         if (req_cmd[p*CMD_W +: CMD_W] != '0) begin
            if (port_busy[p]) begin
               drop_d[p] = 1'b1;
            end else begin
               state_d[p] = S_PENDING;
               cmd_d[p]   = req_cmd[p*CMD_W +: CMD_W];
            end
         end
      end
   end

   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            state_q[p] <= S_EMPTY;
            cmd_q[p]   <= '0;
         end
         alu1_vld <= 1'b0;
         alu1_cmd <= '0;
         alu1_id  <= '0;
         alu2_vld <= 1'b0;
         alu2_cmd <= '0;
         alu2_id  <= '0;
         drop_err <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            state_q[p] <= state_d[p];
            cmd_q[p]   <= cmd_d[p];
         end
         alu1_vld <= vld1_d;
         alu1_cmd <= cmd1_d;
         alu1_id  <= id1_d;
         alu2_vld <= vld2_d;
         alu2_cmd <= cmd2_d;
         alu2_id  <= id2_d;
         drop_err <= drop_d;
      end
   end

`ifdef PRIO_RR_EN
   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr1_q <= ID_W'(NUM_PORTS - 1);
         ptr2_q <= ID_W'(NUM_PORTS - 1);
      end else begin
         if (free1 && g1[ID_W]) ptr1_q <= g1[ID_W-1:0];
         if (free2 && g2[ID_W]) ptr2_q <= g2[ID_W-1:0];
      end
   end
`endif

endmodule

// File: tb/tb_calc_prio_arb.sv
// Bench for calc_prio_arb: directed vector table, hand sequences and a random run against a slot-level model.
module tb_calc_prio_arb;
   localparam int NP  = 4;
   localparam int CW  = 4;
   localparam int SPL = 4;
   localparam int EMPTY = 0, PEND = 1, ISS = 2;

`ifdef PRIO_RR_EN
   localparam logic [1:0] BP_A = 2'd3;
   localparam logic [1:0] BP_B = 2'd0;
`else
   localparam logic [1:0] BP_A = 2'd0;
   localparam logic [1:0] BP_B = 2'd3;
`endif
   localparam logic [3:0] BPM = 4'(1 << BP_B);

   logic          c_clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [15:0]   req_cmd = '0;
   logic [3:0]    port_busy, drop_err;
   logic          alu1_vld, alu2_vld;
   logic [3:0]    alu1_cmd, alu2_cmd;
   logic [1:0]    alu1_id, alu2_id;
   logic          alu1_rdy = 1'b0, alu2_rdy = 1'b0;

   int checks = 0;
   int errors = 0;

   calc_prio_arb #(.NUM_PORTS(NP), .CMD_W(CW), .SPLIT(SPL), .ID_W(2)) dut (
      .c_clk(c_clk), .reset_n(reset_n), .req_cmd(req_cmd),
      .port_busy(port_busy), .drop_err(drop_err),
      .alu1_vld(alu1_vld), .alu1_cmd(alu1_cmd), .alu1_id(alu1_id), .alu1_rdy(alu1_rdy),
      .alu2_vld(alu2_vld), .alu2_cmd(alu2_cmd), .alu2_id(alu2_id), .alu2_rdy(alu2_rdy)
   );

   always #5 c_clk = ~c_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] o(input logic v, input logic [3:0] c, input logic [1:0] i);
      return {v, c, i};
   endfunction

   // slot-level reference model
   int m_st[NP], m_cr[NP], m_drop[NP];
   int m_vld[2], m_cmd[2], m_id[2], m_ptr[2];

   function automatic void m_reset();
      for (int q = 0; q < NP; q++) begin m_st[q] = EMPTY; m_cr[q] = 0; m_drop[q] = 0; end
      for (int a = 0; a < 2; a++) begin m_vld[a] = 0; m_cmd[a] = 0; m_id[a] = 0; m_ptr[a] = NP - 1; end
   endfunction

   function automatic int m_rdy(int a);
      return (a == 0) ? int'(alu1_rdy) : int'(alu2_rdy);
   endfunction

   function automatic int m_req(int q);
      return int'(req_cmd[q*CW +: CW]);
   endfunction

   function automatic bit m_rel(int q);
      if (m_st[q] != ISS) return 1'b0;
      for (int a = 0; a < 2; a++)
         if (m_vld[a] == 1 && m_rdy(a) == 1 && m_id[a] == q) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_busy(int q);
      return (m_st[q] != EMPTY) && !m_rel(q);
   endfunction

   function automatic void m_step();
      int win[2];
      bit rel[NP];
      bit bsy[NP];
      int p;
      for (int q = 0; q < NP; q++) begin rel[q] = m_rel(q); bsy[q] = m_busy(q); end
      for (int a = 0; a < 2; a++) begin
         win[a] = -1;
         if (m_vld[a] == 0 || m_rdy(a) == 1) begin
            for (int k = 0; k < NP; k++) begin
`ifdef PRIO_RR_EN
               p = (m_ptr[a] + 1 + k) % NP;
`else
               p = k;
`endif
               if (win[a] < 0 && m_st[p] == PEND && ((m_cr[p] < SPL) == (a == 0))) win[a] = p;
            end
            m_vld[a] = (win[a] >= 0) ? 1 : 0;
            if (win[a] >= 0) begin
               m_cmd[a] = m_cr[win[a]];
               m_id[a]  = win[a];
               m_ptr[a] = win[a];
            end
         end
      end
      for (int q = 0; q < NP; q++) begin
         m_drop[q] = 0;
         if (rel[q]) m_st[q] = EMPTY;
         if (win[0] == q || win[1] == q) m_st[q] = ISS;
         if (m_req(q) != 0) begin
            if (bsy[q]) m_drop[q] = 1;
            else begin m_st[q] = PEND; m_cr[q] = m_req(q); end
         end
      end
   endfunction

   task automatic m_check();
      logic [3:0] eb, ed;
      for (int q = 0; q < NP; q++) begin eb[q] = m_busy(q); ed[q] = (m_drop[q] != 0); end
      chk("model_alu1", {alu1_vld, alu1_cmd, alu1_id}, o(1'(m_vld[0]), 4'(m_cmd[0]), 2'(m_id[0])));
      chk("model_alu2", {alu2_vld, alu2_cmd, alu2_id}, o(1'(m_vld[1]), 4'(m_cmd[1]), 2'(m_id[1])));
      chk("model_busy", port_busy, eb);
      chk("model_drop", drop_err, ed);
   endtask

   task automatic tick();
      m_check();
      m_step();
      @(negedge c_clk);
   endtask

   // called right after a falling edge; reset asserts mid-cycle and must clear outputs before any edge
   task automatic reset_check(input string nm);
      #2 reset_n = 1'b0;
      #1;
      chk({nm, "_alu1"}, {alu1_vld, alu1_cmd, alu1_id}, 0);
      chk({nm, "_alu2"}, {alu2_vld, alu2_cmd, alu2_id}, 0);
      chk({nm, "_busy"}, port_busy, 0);
      chk({nm, "_drop"}, drop_err, 0);
      m_reset();
      @(negedge c_clk);
      @(negedge c_clk);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [15:0] req;
      logic        r1, r2;
      logic [6:0]  e1, e2;
      logic [3:0]  busy, drop;
   } vec_t;

   vec_t tbl[21];
   int   exp_ids[5];
   int   got[$];

   initial begin
      tbl[0]  = '{16'h0000, 1'b1, 1'b1, o(0,0,0), o(0,0,0),    4'b0000, 4'b0000};
      tbl[1]  = '{16'h0100, 1'b1, 1'b1, o(0,0,0), o(0,0,0),    4'b0000, 4'b0000};
      tbl[2]  = '{16'h0000, 1'b1, 1'b1, o(0,0,0), o(0,0,0),    4'b0100, 4'b0000};
      tbl[3]  = '{16'h0000, 1'b1, 1'b1, o(1,1,2), o(0,0,0),    4'b0000, 4'b0000};
      tbl[4]  = '{16'h0000, 1'b1, 1'b1, o(0,1,2), o(0,0,0),    4'b0000, 4'b0000};
      tbl[5]  = '{16'h0053, 1'b1, 1'b1, o(0,1,2), o(0,0,0),    4'b0000, 4'b0000};
      tbl[6]  = '{16'h0000, 1'b1, 1'b1, o(0,1,2), o(0,0,0),    4'b0011, 4'b0000};
      tbl[7]  = '{16'h0000, 1'b1, 1'b1, o(1,3,0), o(1,5,1),    4'b0000, 4'b0000};
      tbl[8]  = '{16'h0000, 1'b1, 1'b1, o(0,3,0), o(0,5,1),    4'b0000, 4'b0000};
      tbl[9]  = '{16'h8008, 1'b1, 1'b0, o(0,3,0), o(0,5,1),    4'b0000, 4'b0000};
      tbl[10] = '{16'h8008, 1'b1, 1'b0, o(0,3,0), o(0,5,1),    4'b1001, 4'b0000};
      tbl[11] = '{16'h8008, 1'b1, 1'b0, o(0,3,0), o(1,8,BP_A), 4'b1001, 4'b1001};
      tbl[12] = '{16'h0000, 1'b1, 1'b0, o(0,3,0), o(1,8,BP_A), 4'b1001, 4'b1001};
      tbl[13] = '{16'h0000, 1'b1, 1'b1, o(0,3,0), o(1,8,BP_A), BPM,     4'b0000};
      tbl[14] = '{16'h0000, 1'b1, 1'b0, o(0,3,0), o(1,8,BP_B), BPM,     4'b0000};
      tbl[15] = '{16'h0000, 1'b1, 1'b1, o(0,3,0), o(1,8,BP_B), 4'b0000, 4'b0000};
      tbl[16] = '{16'h0000, 1'b1, 1'b1, o(0,3,0), o(0,8,BP_B), 4'b0000, 4'b0000};
      tbl[17] = '{16'h0020, 1'b1, 1'b1, o(0,3,0), o(0,8,BP_B), 4'b0000, 4'b0000};
      tbl[18] = '{16'h0020, 1'b1, 1'b1, o(0,3,0), o(0,8,BP_B), 4'b0010, 4'b0000};
      tbl[19] = '{16'h0000, 1'b1, 1'b1, o(1,2,1), o(0,8,BP_B), 4'b0000, 4'b0010};
      tbl[20] = '{16'h0000, 1'b1, 1'b1, o(0,2,1), o(0,8,BP_B), 4'b0000, 4'b0000};
`ifdef PRIO_RR_EN
      exp_ids = '{0, 1, 2, 3, 0};
`else
      exp_ids = '{0, 1, 0, 1, 0};
`endif

      m_reset();
      repeat (2) @(negedge c_clk);
      reset_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         req_cmd  = tbl[i].req;
         alu1_rdy = tbl[i].r1;
         alu2_rdy = tbl[i].r2;
         #1;
         chk($sformatf("tbl%0d_alu1", i), {alu1_vld, alu1_cmd, alu1_id}, tbl[i].e1);
         chk($sformatf("tbl%0d_alu2", i), {alu2_vld, alu2_cmd, alu2_id}, tbl[i].e2);
         chk($sformatf("tbl%0d_busy", i), port_busy, tbl[i].busy);
         chk($sformatf("tbl%0d_drop", i), drop_err, tbl[i].drop);
         tick();
      end

      // all ports request add-class continuously from a fresh pointer state
      reset_check("rst_pre_arb");
      req_cmd  = 16'h1111;
      alu1_rdy = 1'b1;
      alu2_rdy = 1'b0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (alu1_vld === 1'b1 && got.size() < 5) got.push_back(int'(alu1_id));
         tick();
      end
      chk("arb_count", got.size(), 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("arb_id%0d", i), (i < got.size()) ? got[i] : -1, exp_ids[i]);

      chk("pre_rst_vld", alu1_vld, 1'b1);
      reset_check("rst_mid_xfer");

      for (int c = 0; c < 1500; c++) begin
         for (int q = 0; q < NP; q++)
            req_cmd[q*CW +: CW] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         alu1_rdy = ($urandom_range(0, 9) < 7);
         alu2_rdy = ($urandom_range(0, 9) < 7);
         if (c == 700) begin
            reset_check("rst_random");
         end else begin
            #1;
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/calc_prio_arb.md
# calc_prio_arb

Parametrised priority arbiter for the calc design. It sits between the per-port hold stage and the two ALUs. It captures one pending command per requester port and classifies each command by opcode: add-class goes to ALU1, shift-class goes to ALU2. It issues to each ALU over a valid/ready handshake, using either fixed-priority or round-robin arbitration.

## Interface
- NUM_PORTS, 4, number of requester ports (2..16)
- CMD_W, 4, command width; command 0 means "no request"
- SPLIT, 4, opcode boundary: 1..SPLIT-1 is ALU1 class, SPLIT..2^CMD_W-1 is ALU2 class
- ID_W, $clog2(NUM_PORTS), width of the port id
- c_clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_cmd  in  NUM_PORTS*CMD_W  per-port command; port p occupies bits [p*CMD_W +: CMD_W]
- port_busy  out  NUM_PORTS  slot p holds a command that is not being released this cycle (combinational)
- drop_err  out  NUM_PORTS  one-cycle registered pulse: a command arrived while the port was busy
- alu1_vld / alu2_vld  out  1  ALU request valid
- alu1_cmd / alu2_cmd  out  CMD_W  command being issued
- alu1_id / alu2_id  out  ID_W  source port of the issued command
- alu1_rdy / alu2_rdy  in  1  ALU accepts the request

## Operation
- Each port has a slot with state EMPTY, PENDING or ISSUED, plus a CMD_W command register.
- **Load.** If req_cmd[p] != 0 and port_busy[p] == 0, the command is written and the slot becomes PENDING.
- **Drop.** If req_cmd[p] != 0 and port_busy[p] == 1, the command is discarded, the slot is unchanged, and drop_err[p] = 1 on the next cycle.
- **Release.** When alux_vld & alux_rdy, the slot named by alux_id goes ISSUED to EMPTY. port_busy[p] is already 0 in that cycle, so a new command can load at the same edge (the slot goes ISSUED to PENDING).
- **Eligibility.**
  - ALU1: PENDING slots with 1 <= cmd < SPLIT.
  - ALU2: PENDING slots with cmd >= SPLIT.
  - The two classes are disjoint, so a slot is never offered to both ALUs.
- **Grant.** Issue a new grant only when the output is free, i.e. alux_vld == 0 or a handshake happens this cycle.
  - On grant, register cmd and id, set alux_vld = 1, and move the slot PENDING to ISSUED.
  - If nothing is eligible, alux_vld = 0 and cmd/id keep their last values.
- **Hold.** While alux_vld == 1 and alux_rdy == 0, vld/cmd/id are held stable and no other slot of that class is granted.
- **Ordering.** Both ALUs arbitrate independently in the same cycle. A slot made PENDING at edge N becomes eligible from edge N+1 onward.
- **Fixed priority** (default): lowest eligible port index wins.
- **Arithmetic.** Opcode comparisons are unsigned. The id is the binary port index and wraps at NUM_PORTS-1 to 0 in round-robin search.

## Timing
- **Reset** (reset_n low, asynchronous):
  - all slots EMPTY, command registers 0
  - alu1/2_vld = 0, alu1/2_cmd = 0, alu1/2_id = 0
  - drop_err = 0, port_busy = 0
  - round-robin pointers = NUM_PORTS-1
- Reset deassertion is synchronised externally. The first load happens at the first rising edge after reset_n goes high.
- **Latency.** Command presented in cycle 0, slot PENDING after edge 1, alux_vld high after edge 2. Minimum latency is 2 cycles.
- **Throughput.** With rdy held high, each ALU accepts one command per cycle: a handshake edge grants the next eligible slot at that same edge.
- **Reset mid-operation.** Issued and pending commands are lost. alux_vld drops asynchronously and no handshake completes.
- **Simultaneous release of both ALUs.** Both slots free at the same edge.
- **Simultaneous drop.** drop_err is per port, so several bits may pulse together.

## Configuration
- PRIO_RR_EN defined: round-robin arbitration.
  - Each ALU keeps a pointer to its last granted port.
  - The search starts at pointer+1, modulo NUM_PORTS.
  - The pointer updates only on grant.
- PRIO_RR_EN undefined: fixed priority, lowest index first. Pointer logic is not compiled in.

## Test plan
- **Reset, then single request.** Set port 2 req_cmd = 4'h1 for one cycle with alu1_rdy = 1. Required: alu1_vld high 2 cycles later with cmd = 1 and id = 2, then slot 2 EMPTY, and alu2_vld stays 0.
- **Class split.** In the same cycle set port 0 = 4'h3 and port 1 = 4'h5. Required: in the same cycle, alu1 shows (3, id 0) and alu2 shows (5, id 1).
- **Backpressure.** Keep alu2_rdy = 0 with ports 0 and 3 holding 4'h8. Required: alu2 holds (8, id 0) stable. After rdy = 1 for one cycle, (8, id 3) follows on the next cycle.
- **Drop.** Port 1 is PENDING and receives 4'h2 again. Required: drop_err[1] pulses one cycle later and the original command is issued unchanged.
- **Arbitration mode.** All 4 ports continuously request 4'h1 with alu1_rdy = 1.
  - With PRIO_RR_EN: ids issue 0,1,2,3,0.
  - Without it: port 0 wins whenever it is PENDING, so the sequence is 0,1,0,1 when port 0 reloads every cycle.
- **Async reset mid-transfer.** Pull reset_n low while alu1_vld = 1. Required: vld goes 0 immediately and all outputs return to reset values.
